// File: rtl/bus_ep_pkg.sv
// Shared constants and helpers for the bus endpoint: destination field
// geometry, broadcast default, statistics counter width and saturation.
package bus_ep_pkg;

  localparam int unsigned DEST_W       = 8;
  localparam int unsigned DEST_MSB_OFS = 0;
  localparam logic [DEST_W-1:0] BCAST_DEFAULT = 8'hFF;
  localparam int unsigned CNT_W        = 8;

  // Adds 0..3 to a statistics counter, sticking at all-ones.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
    return (s[CNT_W] == 1'b1) ? '1 : s[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/bus_ep_if.sv
// Bus-side handshake of the endpoint: TX request/pop toward the bus and
// RX push from the bus. master = bus fabric, slave = endpoint.
interface bus_ep_if #(
  parameter int unsigned pckg_sz = 16
) ();

  logic               pndng;
  logic [pckg_sz-1:0] D_pop;
  logic               pop;
  logic               push;
  logic [pckg_sz-1:0] D_push;

  modport master (input pndng, D_pop, output pop, push, D_push);
  modport slave  (output pndng, D_pop, input pop, push, D_push);

endinterface

// File: rtl/bus_ep_fifo.sv
// First-word fall-through FIFO with full/empty flags; a write while full is
// accepted only when a read retires the head in the same cycle.
module bus_ep_fifo #(
  parameter int unsigned width = 16,
  parameter int unsigned depth = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [width-1:0] wr_data,
  input  logic             rd,
  output logic [width-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  localparam int unsigned AW = $clog2(depth);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [width-1:0] mem_q [depth];
  logic             rd_en, wr_en;

  assign full    = (count_q == CW'(depth));
  assign empty   = (count_q == '0);
  assign rd_en   = rd && !empty;
  assign wr_en   = wr && (!full || rd_en);
  assign drop    = wr && !wr_en;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // When full, the tail slot is the head slot; the head is consumed this same
  // cycle, so overwriting it on a simultaneous read+write is safe.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/bus_endpoint.sv
// Bus endpoint: host TX FIFO toward the bus, RX FIFO from the bus, overflow
// and filter statistics. Optional address filter: BUS_EP_ADDR_FILTER_EN.
module bus_endpoint
  import bus_ep_pkg::*;
#(
  parameter int unsigned       pckg_sz    = 16,
  parameter int unsigned       fifo_depth = 16,
  parameter logic [DEST_W-1:0] id         = '0,
  parameter logic [DEST_W-1:0] broadcast  = BCAST_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tx_wr,
  input  logic [pckg_sz-1:0] tx_data,
  output logic               tx_full,
  input  logic               rx_rd,
  output logic [pckg_sz-1:0] rx_data,
  output logic               rx_empty,
  output logic [CNT_W-1:0]   ovf_cnt,
  output logic [CNT_W-1:0]   flt_cnt,
  bus_ep_if.slave            bus
);

  logic              tx_empty, tx_drop, rx_drop;
  logic              rx_accept, rx_wr, dest_match;
  logic [DEST_W-1:0] dest;
  logic [CNT_W-1:0]  ovf_q, ovf_d;

  bus_ep_fifo #(.width(pckg_sz), .depth(fifo_depth)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr      (tx_wr),
    .wr_data (tx_data),
    .rd      (bus.pop),
    .rd_data (bus.D_pop),
    .full    (tx_full),
    .empty   (tx_empty),
    .drop    (tx_drop)
  );

  assign bus.pndng = !tx_empty;

  assign dest       = bus.D_push[pckg_sz-1-DEST_MSB_OFS -: DEST_W];
  assign dest_match = (dest == id) || (dest == broadcast);
  assign rx_wr      = bus.push && rx_accept;

  bus_ep_fifo #(.width(pckg_sz), .depth(fifo_depth)) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr      (rx_wr),
    .wr_data (bus.D_push),
    .rd      (rx_rd),
    .rd_data (rx_data),
    .full    (),
    .empty   (rx_empty),
    .drop    (rx_drop)
  );

  always_comb begin
    ovf_d = sat_add(ovf_q, {1'b0, tx_drop} + {1'b0, rx_drop});
  end

  always_ff @(posedge clk) begin
    if (reset) ovf_q <= '0;
    else       ovf_q <= ovf_d;
  end

  assign ovf_cnt = ovf_q;

`ifdef BUS_EP_ADDR_FILTER_EN
  logic [CNT_W-1:0] flt_q, flt_d;

  assign rx_accept = dest_match;

  always_comb begin
    flt_d = sat_add(flt_q, {1'b0, bus.push && !dest_match});
  end

  always_ff @(posedge clk) begin
    if (reset) flt_q <= '0;
    else       flt_q <= flt_d;
  end

  assign flt_cnt = flt_q;
`else
  logic unused_dest_match;

  assign rx_accept         = 1'b1;
  assign flt_cnt           = '0;
  assign unused_dest_match = dest_match;
`endif

endmodule

// File: doc/bus_endpoint.md
BUS_ENDPOINT -- requirements
Module: bus_endpoint

Interface
REQ-001 Parameter pckg_sz, default 16, packet width in bits; destination field is bits [pckg_sz-1 -: 8].
REQ-002 Parameter fifo_depth, default 16, entries per FIFO; power of two, at least 2.
REQ-003 Parameter id, default 0, 8-bit own address of this endpoint.
REQ-004 Parameter broadcast, default 8'hFF, destination value accepted by every endpoint.
REQ-005 clk  input  1  single clock; all logic on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 tx_wr  input  1  host write strobe into the TX FIFO.
REQ-008 tx_data  input  pckg_sz  host packet to transmit.
REQ-009 tx_full  output  1  TX FIFO holds fifo_depth entries.
REQ-010 pndng  output  1  TX FIFO non-empty; request toward the bus.
REQ-011 D_pop  output  pckg_sz  head of the TX FIFO, first-word fall-through.
REQ-012 pop  input  1  bus consumes the head of the TX FIFO.
REQ-013 push  input  1  bus delivers a packet to this endpoint.
REQ-014 D_push  input  pckg_sz  packet delivered by the bus.
REQ-015 rx_rd  input  1  host read strobe from the RX FIFO.
REQ-016 rx_data  output  pckg_sz  head of the RX FIFO, first-word fall-through.
REQ-017 rx_empty  output  1  RX FIFO holds no entries.
REQ-018 ovf_cnt  output  8  saturating count of packets lost to a full FIFO (TX writes plus RX pushes).
REQ-019 flt_cnt  output  8  saturating count of RX packets discarded by the address filter.

Function
REQ-020 tx_wr with tx_full low SHALL store tx_data at the tail; pndng SHALL rise on the next cycle.
REQ-021 tx_wr with tx_full high and pop low SHALL discard tx_data and increment ovf_cnt.
REQ-022 tx_wr and pop in the same cycle while full SHALL perform both operations; occupancy stays fifo_depth and no overflow is counted.
REQ-023 D_pop SHALL present the head whenever pndng is high; pop SHALL advance the head on the next cycle.
REQ-024 pop with pndng low SHALL be ignored: no pointer change and no count.
REQ-025 push SHALL store D_push in the RX FIFO only if it is accepted (REQ-031) and the RX FIFO is not full, or it is full and rx_rd is high in the same cycle.
REQ-026 An accepted push to a full RX FIFO with rx_rd low SHALL be dropped and increment ovf_cnt.
REQ-027 rx_rd with rx_empty high SHALL be ignored.
REQ-028 FIFO pointers SHALL wrap modulo fifo_depth; occupancy counters SHALL be clog2(fifo_depth)+1 bits wide.
REQ-029 ovf_cnt and flt_cnt SHALL saturate at 8'hFF.
REQ-030 When a TX overflow and an RX overflow occur in the same cycle, ovf_cnt SHALL increase by 2, saturating at 8'hFF.

Configuration
REQ-031 With BUS_EP_ADDR_FILTER_EN defined, a push is accepted only if its destination equals id or broadcast; any other push is discarded and increments flt_cnt.
REQ-032 Without BUS_EP_ADDR_FILTER_EN, every push is accepted and flt_cnt is tied to 0.

Reset
REQ-033 With reset high at a clock edge, both FIFOs SHALL empty and both counters SHALL clear.
REQ-034 During and after reset: pndng=0, tx_full=0, rx_empty=1, ovf_cnt=0, flt_cnt=0; D_pop and rx_data are don't-care.
REQ-035 Reset SHALL take priority over simultaneous tx_wr, pop, push and rx_rd; none of these strobes take effect.

Structure
REQ-036 Package bus_ep_pkg SHALL hold the destination-field offset and width, the broadcast default and the counter width.
REQ-037 Both FIFOs SHALL be instances of one sub-module, bus_ep_fifo (parameterised width/depth, FWFT, full/empty).

Verification
REQ-038 Write 16'h0105 then 16'h0207 with id=1 -> pndng rises next cycle, D_pop=16'h0105, and after one pop D_pop=16'h0207.
REQ-039 Write 17 packets into a depth-16 FIFO with no pop -> tx_full high after the 16th write; 17th write dropped; ovf_cnt=1.
REQ-040 With the filter enabled and id=2, push 16'h0211, 16'hFF22, 16'h0333 -> RX holds 16'h0211 and 16'hFF22; flt_cnt=1.
REQ-041 With RX full, assert push and rx_rd together -> occupancy stays 16, ovf_cnt unchanged, and the new packet appears at the tail.
REQ-042 Assert reset while 5 TX and 3 RX entries are held and pop is high -> next cycle pndng=0, rx_empty=1, counters=0.
REQ-043 Pop while empty, and rx_rd while empty -> no state change; force 300 overflows -> ovf_cnt holds at 8'hFF.
